// File: rtl/adder_check_pkg.sv
// Shared definitions for the carry-select adder checking path.
//   - check_state_e : checker FSM states (OK, SUSPECT, FAULT)
//   - RES_W         : width of a mod-3 residue
//   - mod3_weight   : weight of a bit position modulo 3 (1, 2, 1, 2, ... from LSB)
//   - mod3_add      : addition of two residues modulo 3
package adder_check_pkg;

    localparam int RES_W = 2;

    typedef enum logic [1:0] {
        OK      = 2'd0,
        SUSPECT = 2'd1,
        FAULT   = 2'd2
    } check_state_e;

    // 2^i mod 3 is 1 for even i and 2 for odd i.
    function automatic logic [RES_W-1:0] mod3_weight(input int idx);
        logic [31:0] idx_bits;
        idx_bits = idx;
        return idx_bits[0] ? 2'd2 : 2'd1;
    endfunction

    // Both operands are assumed already reduced (0..2), so one conditional
    // subtraction is enough.
    function automatic logic [RES_W-1:0] mod3_add(input logic [RES_W-1:0] x,
                                                  input logic [RES_W-1:0] y);
        logic [RES_W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[RES_W-1:0];
    endfunction

endpackage

// File: rtl/mod3_residue.sv
// Combinational mod-3 residue of a W-bit unsigned value.
// Ports:
//   din : W-bit value to reduce
//   res : residue din mod 3, range 0..2
module mod3_residue
    import adder_check_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0]     din,
    output logic [RES_W-1:0] res
);

    logic [RES_W-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < W; i++) begin
            if (din[i]) begin
                acc = mod3_add(acc, mod3_weight(i));
            end
        end
        res = acc;
    end

endmodule

// File: rtl/csa_result_checker.sv
// Registered checker stage behind the 16-bit carry-select adder.
// Captures operands/result through a valid/ready handshake, checks each
// result with a mod-3 residue test, counts failures and escalates repeated
// consecutive failures to a sticky FAULT state that stops accepting input.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : upstream handshake
//   in_a, in_b, in_cin  : adder operands and carry-in
//   in_sum, in_cout     : adder result under test
//   out_valid/out_ready : downstream handshake
//   out_sum, out_cout   : registered result
//   out_err             : residue mismatch for the registered result
//   fault               : sticky fault indication
//   err_cnt             : saturating count of residue failures
//   clr_fault           : clears fault, err_cnt and consecutive count
module csa_result_checker
    import adder_check_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int FAULT_THRESH = 3,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_err,
    output logic             fault,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             clr_fault
);

    // FAULT_THRESH is at most 15, so 4 bits always hold the consecutive count.
    localparam int              CONS_W   = 4;
    localparam logic [CONS_W-1:0] THRESH_L = CONS_W'(FAULT_THRESH);

    logic [RES_W-1:0] res_a;
    logic [RES_W-1:0] res_b;
    logic [RES_W-1:0] res_s;
    logic [RES_W-1:0] res_exp;
    logic             res_err;
    logic             accept;

    check_state_e     state_q,     state_d;
    logic [CONS_W-1:0] cons_q,     cons_d;
    logic [CONS_W-1:0] cons_inc;
    logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;
    logic             fault_q,     fault_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_sum_q,   out_sum_d;
    logic             out_cout_q,  out_cout_d;
    logic             out_err_q,   out_err_d;

    mod3_residue #(.W(WIDTH)) u_res_a (
        .din (in_a),
        .res (res_a)
    );

    mod3_residue #(.W(WIDTH)) u_res_b (
        .din (in_b),
        .res (res_b)
    );

    // The carry-out is bit WIDTH of the true sum, so it joins the residue.
    mod3_residue #(.W(WIDTH + 1)) u_res_s (
        .din ({in_cout, in_sum}),
        .res (res_s)
    );

    always_comb begin
        res_exp = mod3_add(mod3_add(res_a, res_b), {1'b0, in_cin});
        res_err = (res_exp != res_s);
    end

    // Ready depends on out_ready combinationally so a full register can be
    // replaced in the same cycle it drains.
    always_comb begin
        in_ready = (state_q != FAULT) && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
    end

    // Output register: load on accept, drop valid once consumed, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_cout_d  = out_cout_q;
        out_err_d   = out_err_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_sum_d   = in_sum;
            out_cout_d  = in_cout;
            out_err_d   = res_err;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Fault escalation. OK and SUSPECT share the same rule: an error bumps
    // the consecutive count and enters FAULT when it reaches the threshold,
    // which also covers the FAULT_THRESH==1 direct OK->FAULT path.
    always_comb begin
        state_d   = state_q;
        cons_d    = cons_q;
        err_cnt_d = err_cnt_q;
        cons_inc  = cons_q + 1'b1;

        if (accept && res_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end

        case (state_q)
            OK, SUSPECT: begin
                if (accept) begin
                    if (res_err) begin
                        cons_d  = cons_inc;
                        state_d = (cons_inc == THRESH_L) ? FAULT : SUSPECT;
                    end else begin
                        cons_d  = '0;
                        state_d = OK;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = OK;
                cons_d  = '0;
            end
        endcase

        // Clear has priority over any same-cycle error bookkeeping; the
        // registered out_err of that transfer is unaffected.
        if (clr_fault) begin
            state_d   = OK;
            cons_d    = '0;
            err_cnt_d = '0;
        end

        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= OK;
            cons_q      <= '0;
            err_cnt_q   <= '0;
            fault_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cons_q      <= cons_d;
            err_cnt_q   <= err_cnt_d;
            fault_q     <= fault_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_err   = out_err_q;
    assign fault     = fault_q;
    assign err_cnt   = err_cnt_q;

endmodule
